// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: byte width, the arbiter
// state encoding and the default header tag used when UART_ARB_HDR_EN is
// defined.
package uart_pkg;

    // Width of one byte on the uart_tx port
    localparam int UART_BYTE_W = 8;

    // Default upper nibble of the optional packet header byte
    localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;

    // Arbiter state encoding; S_HDR is only reachable with UART_ARB_HDR_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. Searches req upward starting at
// (last_grant+1) mod NUM_CH and returns the first requester both as a
// one-hot vector and as an index. pick is all-zero when nobody requests.
module rr_pick #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [2:0]        last_grant,
    output logic [NUM_CH-1:0] pick,
    output logic [2:0]        idx
);

    logic [3:0]          start;
    logic [3:0]          cand;
    logic [2*NUM_CH-1:0] req2;
    logic [2*NUM_CH-1:0] rot;
    logic                found;

    // Rotate the request vector so the preferred channel lands at bit 0,
    // then take the lowest set bit and map it back to a channel number.
    always_comb begin
        start = {1'b0, last_grant} + 4'd1;
        if (start >= 4'(NUM_CH)) begin
            start = start - 4'(NUM_CH);
        end
        req2  = {req, req};
        rot   = req2 >> start;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                cand  = start + 4'(k);
                if (cand >= 4'(NUM_CH)) begin
                    cand = cand - 4'(NUM_CH);
                end
                idx = cand[2:0];
            end
        end
        pick = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            pick[j] = found && (idx == 3'(j));
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx byte port among
// NUM_CH requesters. A grant is held from the first byte of a packet until
// its last byte is accepted; a watchdog revokes a grant whose owner stalls
// mid-packet for TIMEOUT cycles.
//
// Optional feature macro: UART_ARB_HDR_EN. When defined, each granted
// packet is preceded by a header byte {HDR_TAG, 1'b0, grant_id}.
//
// Handshake: a byte moves on a cycle where valid && ready are both high on
// the same interface. The producer holds data stable while valid is high
// and not yet accepted; valid never waits on ready. On the requester side
// req_ready[g] is simply tx_data_ready routed to the owner g, so a request
// byte and the tx byte transfer on the same edge.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 1024
`ifdef UART_ARB_HDR_EN
    ,
    parameter logic [3:0] HDR_TAG = HDR_TAG_DEFAULT
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             req_valid,
    input  logic [NUM_CH-1:0]             req_last,
    input  logic [UART_BYTE_W*NUM_CH-1:0] req_data,
    output logic [NUM_CH-1:0]             req_ready,
    output logic [UART_BYTE_W-1:0]        tx_data,
    output logic                          tx_data_valid,
    input  logic                          tx_data_ready,
    output logic [2:0]                    grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    arb_state_t             state;
    logic [2:0]             last_grant;
    logic [15:0]            wd_cnt;

    logic [NUM_CH-1:0]      pick;
    logic [2:0]             pick_idx;
    logic                   pick_any;

    logic                   g_valid;
    logic                   g_last;
    logic [UART_BYTE_W-1:0] g_data;
    logic                   xfer;

    rr_pick #(
        .NUM_CH(NUM_CH)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .pick       (pick),
        .idx        (pick_idx)
    );

    assign pick_any = |pick;
    assign xfer     = tx_data_valid && tx_data_ready;
    assign busy     = (state != S_IDLE);

    // Select the current owner's valid/last/data lanes.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_id == 3'(c)) begin
                g_valid = req_valid[c];
                g_last  = req_last[c];
                g_data  = req_data[UART_BYTE_W*c +: UART_BYTE_W];
            end
        end
    end

    // Drive the tx port and route tx_data_ready back to the owner only.
    always_comb begin
        tx_data       = '0;
        tx_data_valid = 1'b0;
        req_ready     = '0;
        case (state)
            S_DATA: begin
                tx_data_valid = g_valid;
                tx_data       = g_data;
                for (int c = 0; c < NUM_CH; c++) begin
                    req_ready[c] = (grant_id == 3'(c)) && tx_data_ready;
                end
            end
`ifdef UART_ARB_HDR_EN
            S_HDR: begin
                tx_data       = {HDR_TAG, 1'b0, grant_id};
                tx_data_valid = 1'b1;
            end
`endif
            default: begin
                tx_data       = '0;
                tx_data_valid = 1'b0;
            end
        endcase
    end

    // Arbitration FSM with the mid-packet stall watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            grant_id    <= '0;
            last_grant  <= 3'(NUM_CH - 1);
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    // No bytes move here; the grant takes effect next cycle.
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        wd_cnt   <= '0;
`ifdef UART_ARB_HDR_EN
                        state    <= S_HDR;
`else
                        state    <= S_DATA;
`endif
                    end
                end
`ifdef UART_ARB_HDR_EN
                S_HDR: begin
                    // Watchdog stays disarmed until the header has gone out.
                    if (tx_data_ready) begin
                        wd_cnt <= '0;
                        state  <= S_DATA;
                    end
                end
`endif
                S_DATA: begin
                    if (xfer) begin
                        wd_cnt <= '0;
                        if (g_last) begin
                            last_grant <= grant_id;
                            state      <= S_IDLE;
                        end
                    end else if (!g_valid) begin
                        // Owner starved the port; abandon its partial packet.
                        if (wd_cnt == WD_LAST) begin
                            timeout_err <= 1'b1;
                            last_grant  <= grant_id;
                            wd_cnt      <= '0;
                            state       <= S_IDLE;
                        end else begin
                            wd_cnt <= wd_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    wd_cnt <= '0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
